// File: rtl/processing_unit_mc_if.sv
// Request/result bundle for processing_unit_mc: operands and opcode in,
// registered results, status flags and the busy/done handshake out.
interface processing_unit_mc_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic [7:0]       operation;
   logic [WIDTH-1:0] result_data;
   logic [WIDTH-1:0] result_hi;
   logic             overflow;
   logic             div_zero;
   logic             busy;
   logic             done;

   modport master (
      output start, data_a, data_b, operation,
      input  result_data, result_hi, overflow, div_zero, busy, done
   );

   modport slave (
      input  start, data_a, data_b, operation,
      output result_data, result_hi, overflow, div_zero, busy, done
   );
endinterface

// File: rtl/processing_unit_mc.sv
// Multi-cycle WIDTH-bit processing unit: add/sub/and/or in one cycle, shift-add
// multiply and restoring divide one bit per clock. Define PU_SATURATE_EN for saturating results.
module processing_unit_mc #(
   parameter int WIDTH = 8
) (
   input logic                 reset,
   input logic                 clock,
   processing_unit_mc_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [7:0] OP_ADD = 8'h2B;
   localparam logic [7:0] OP_SUB = 8'h2D;
   localparam logic [7:0] OP_MUL = 8'h2A;
   localparam logic [7:0] OP_DIV = 8'h2F;
   localparam logic [7:0] OP_AND = 8'h26;
   localparam logic [7:0] OP_OR  = 8'h7C;
`ifdef PU_SATURATE_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result, r_resultHi;
   logic             r_overflow, r_divZero, r_busy, r_done;

   logic [WIDTH:0]   w_sum, w_diff, w_mulSum, w_divShift;
   logic [WIDTH-1:0] w_mulHi, w_mulLo, w_mulRes, w_divRem, w_divQuot;
   logic [WIDTH-1:0] w_immRes, w_immHi;
   logic             w_immOvf, w_immDz, w_toMul, w_toDiv, w_divGe, w_lastIter;

   // Single-cycle results straight from the inputs, plus one multiply/divide step
   // on the working registers. r_hi/r_lo hold {product high, multiplier} or {remainder, dividend}.
   always_comb begin
      w_sum      = {1'b0, bus.data_a} + {1'b0, bus.data_b};
      w_diff     = {1'b0, bus.data_a} - {1'b0, bus.data_b};
      w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
      w_mulHi    = w_mulSum[WIDTH:1];
      w_mulLo    = {w_mulSum[0], r_lo[WIDTH-1:1]};
      w_mulRes   = (SATURATE && (w_mulHi != '0)) ? '1 : w_mulLo;
      w_divShift = {r_hi, r_lo[WIDTH-1]};
      w_divGe    = (w_divShift >= {1'b0, r_b});
      w_divRem   = w_divGe ? WIDTH'(w_divShift - {1'b0, r_b}) : w_divShift[WIDTH-1:0];
      w_divQuot  = {r_lo[WIDTH-2:0], w_divGe};
      w_lastIter = (r_cnt == CW'(WIDTH - 1));

      w_immRes = '0;
      w_immHi  = '0;
      w_immOvf = 1'b0;
      w_immDz  = 1'b0;
      w_toMul  = 1'b0;
      w_toDiv  = 1'b0;
      case (bus.operation)
         OP_ADD: begin
            w_immRes = (SATURATE && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
            w_immOvf = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_immRes = (SATURATE && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
            w_immOvf = w_diff[WIDTH];
         end
         OP_AND: w_immRes = bus.data_a & bus.data_b;
         OP_OR:  w_immRes = bus.data_a | bus.data_b;
         OP_MUL: w_toMul = 1'b1;
         OP_DIV: begin
            if (bus.data_b == '0) begin
               w_immRes = '1;
               w_immHi  = bus.data_a;
               w_immDz  = 1'b1;
            end else begin
               w_toDiv = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Control FSM. Visible results only change on completion, so iterations never leak out.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_resultHi <= '0;
         r_overflow <= 1'b0;
         r_divZero  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a   <= bus.data_a;
                  r_b   <= bus.data_b;
                  r_cnt <= '0;
                  if (w_toMul) begin
                     r_hi    <= '0;
                     r_lo    <= bus.data_b;
                     r_busy  <= 1'b1;
                     r_state <= MUL;
                  end else if (w_toDiv) begin
                     r_hi    <= '0;
                     r_lo    <= bus.data_a;
                     r_busy  <= 1'b1;
                     r_state <= DIV;
                  end else begin
                     r_result   <= w_immRes;
                     r_resultHi <= w_immHi;
                     r_overflow <= w_immOvf;
                     r_divZero  <= w_immDz;
                     r_done     <= 1'b1;
                  end
               end
            end
            MUL: begin
               r_hi  <= w_mulHi;
               r_lo  <= w_mulLo;
               r_cnt <= r_cnt + CW'(1);
               if (w_lastIter) begin
                  r_result   <= w_mulRes;
                  r_resultHi <= w_mulHi;
                  r_overflow <= (w_mulHi != '0);
                  r_divZero  <= 1'b0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            DIV: begin
               r_hi  <= w_divRem;
               r_lo  <= w_divQuot;
               r_cnt <= r_cnt + CW'(1);
               if (w_lastIter) begin
                  r_result   <= w_divQuot;
                  r_resultHi <= w_divRem;
                  r_overflow <= 1'b0;
                  r_divZero  <= 1'b0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.result_data = r_result;
   assign bus.result_hi   = r_resultHi;
   assign bus.overflow    = r_overflow;
   assign bus.div_zero    = r_divZero;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
endmodule

// File: tb/tb_processing_unit_mc.sv
// Self-checking bench for processing_unit_mc (WIDTH=8): directed cases plus
// random operations checked against a plain-arithmetic reference model.
module tb_processing_unit_mc;
   localparam int W = 8;
   localparam longint unsigned MASK = (64'd1 << W) - 1;
   localparam logic [7:0] OP_ADD = 8'h2B;
   localparam logic [7:0] OP_SUB = 8'h2D;
   localparam logic [7:0] OP_MUL = 8'h2A;
   localparam logic [7:0] OP_DIV = 8'h2F;
   localparam logic [7:0] OP_AND = 8'h26;
   localparam logic [7:0] OP_OR  = 8'h7C;
   localparam logic [7:0] OP_BAD = 8'h41;
`ifdef PU_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   failed = 0;

   processing_unit_mc_if #(.WIDTH(W)) bus ();
   processing_unit_mc #(.WIDTH(W)) dut (.reset(reset), .clock(clock), .bus(bus.slave));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected outcome of one operation, computed directly from the arithmetic rules
   function automatic void refModel(input logic [7:0] op, input longint unsigned a, input longint unsigned b,
                                    output longint unsigned res, output longint unsigned hi,
                                    output bit ovf, output bit dz, output int lat);
      longint unsigned p;
      res = 0; hi = 0; ovf = 0; dz = 0; lat = 1;
      case (op)
         OP_ADD: begin
            p = a + b; res = p & MASK; ovf = (p > MASK);
            if (SAT && ovf) res = MASK;
         end
         OP_SUB: begin
            res = (a - b) & MASK; ovf = (a < b);
            if (SAT && ovf) res = 0;
         end
         OP_MUL: begin
            p = a * b; res = p & MASK; hi = p >> W; ovf = (hi != 0); lat = W + 1;
            if (SAT && ovf) res = MASK;
         end
         OP_DIV: begin
            if (b == 0) begin res = MASK; hi = a; dz = 1; end
            else begin res = a / b; hi = a % b; lat = W + 1; end
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         default: ;
      endcase
   endfunction

   task automatic applyStimulus(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      bus.start = 1'b1; bus.operation = op; bus.data_a = a; bus.data_b = b;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit mutate, input bit extraStart);
      longint unsigned eRes, eHi;
      bit eOvf, eDz;
      int eLat, cyc, extra;
      refModel(op, a, b, eRes, eHi, eOvf, eDz, eLat);
      check({tag, "_busy"}, bus.busy, (eLat > 1));
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 4 * W) begin
         if (mutate) bus.data_a = ~bus.data_a;
         bus.start = extraStart && (cyc == 3);
         @(negedge clock);
         cyc++;
      end
      bus.start = 1'b0;
      check({tag, "_latency"}, cyc, eLat);
      check({tag, "_result"}, bus.result_data, eRes);
      check({tag, "_hi"}, bus.result_hi, eHi);
      check({tag, "_ovf"}, bus.overflow, eOvf);
      check({tag, "_dz"}, bus.div_zero, eDz);
      check({tag, "_idle"}, bus.busy, 1'b0);
      @(negedge clock);
      check({tag, "_pulse"}, bus.done, 1'b0);
      if (extraStart) begin
         extra = 0;
         repeat (W + 3) begin
            @(negedge clock);
            if (bus.done) extra++;
         end
         check({tag, "_ignored"}, extra, 0);
      end
   endtask

   task automatic runOp(input string tag, input logic [7:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit mutate, input bit extraStart);
      applyStimulus(op, a, b);
      checkOutput(tag, op, a, b, mutate, extraStart);
   endtask

   task automatic checkZero(input string tag);
      check({tag, "_result"}, bus.result_data, 0);
      check({tag, "_hi"}, bus.result_hi, 0);
      check({tag, "_flags"}, {bus.overflow, bus.div_zero, bus.busy, bus.done}, 0);
   endtask

   initial begin
      logic [7:0] ops [7];
      int seenDone;
      ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_BAD};
      bus.start = 1'b0; bus.data_a = '0; bus.data_b = '0; bus.operation = OP_ADD;

      bus.start = 1'b1;
      repeat (2) @(negedge clock);
      checkZero("reset");
      bus.start = 1'b0;
      reset = 1'b1;
      @(negedge clock);

      runOp("add_ovf", OP_ADD, 8'd200, 8'd100, 1'b0, 1'b0);
      runOp("sub_borrow", OP_SUB, 8'd3, 8'd5, 1'b0, 1'b0);
      runOp("and", OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);
      runOp("mul16x16", OP_MUL, 8'd16, 8'd16, 1'b0, 1'b0);
      runOp("mul15x17", OP_MUL, 8'd15, 8'd17, 1'b0, 1'b0);
      runOp("div_mutate", OP_DIV, 8'd200, 8'd7, 1'b1, 1'b0);
      runOp("div_busystart", OP_DIV, 8'd200, 8'd7, 1'b0, 1'b1);
      runOp("div_zero", OP_DIV, 8'd5, 8'd0, 1'b0, 1'b0);
      runOp("add_clear_dz", OP_ADD, 8'd1, 8'd1, 1'b0, 1'b0);
      runOp("invalid", OP_BAD, 8'd9, 8'd9, 1'b0, 1'b0);
      runOp("mul_max", OP_MUL, 8'd255, 8'd255, 1'b0, 1'b0);

      // Back-to-back: a new start during the done cycle is accepted
      applyStimulus(OP_ADD, 8'd10, 8'd20);
      check("b2b_first_done", bus.done, 1'b1);
      check("b2b_first_result", bus.result_data, 30);
      bus.start = 1'b1; bus.operation = OP_AND; bus.data_a = 8'hF0; bus.data_b = 8'h3C;
      @(negedge clock);
      bus.start = 1'b0;
      check("b2b_second_done", bus.done, 1'b1);
      check("b2b_second_result", bus.result_data, 8'h30);

      // Reset in the middle of a divide aborts it without a done pulse
      applyStimulus(OP_DIV, 8'd200, 8'd7);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      checkZero("midreset");
      @(negedge clock);
      reset = 1'b1;
      seenDone = 0;
      repeat (W + 4) begin
         @(negedge clock);
         if (bus.done) seenDone++;
      end
      check("midreset_nodone", seenDone, 0);
      runOp("or_after_reset", OP_OR, 8'h0F, 8'hA0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] op;
         logic [W-1:0] a, b;
         op = ops[$urandom_range(0, 6)];
         a = W'($urandom_range(0, 255));
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
         runOp($sformatf("rand%0d_op%0h", i, op), op, a, b, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/processing_unit_mc.md
Name: processing_unit_mc

Overview:
- Parametrised, multi-cycle successor of the team's 8-bit processing unit.
- Accepts one operation per start handshake and runs it on WIDTH-bit unsigned operands: add, subtract, shift-add multiply, restoring divide, AND, OR.
- Returns a registered WIDTH-bit result, an upper half (product high / remainder) and status flags.
- Sits between the operand/opcode register stage and the display/result path of the warm-up datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- reset  input  1  asynchronous, active-low reset
- clock  input  1  rising-edge clock
- start  input  1  request; sampled only while busy=0
- data_a  input  WIDTH  operand A, unsigned
- data_b  input  WIDTH  operand B, unsigned
- operation  input  8  ASCII opcode: 0x2B '+', 0x2D '-', 0x2A '*', 0x2F '/', 0x26 '&', 0x7C '|'
- result_data  output  WIDTH  low result: sum, difference, product low, quotient, or logic result
- result_hi  output  WIDTH  product high half for '*', remainder for '/', otherwise 0
- overflow  output  1  result does not fit in WIDTH bits
- div_zero  output  1  '/' attempted with data_b=0
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse; result and flags are valid

Behaviour:
- Reset (reset=0, async): result_data=0, result_hi=0, overflow=0, div_zero=0, busy=0, done=0, FSM=IDLE, iteration counter=0, internal operand registers=0.
- Reset mid-operation aborts the operation with no done pulse. The first start after reset release is accepted.
- FSM states: IDLE, MUL, DIV.
  - IDLE: a start=1 at a rising edge is accepted. data_a, data_b and operation are latched on that edge; later input changes have no effect.
  - '+', '-', '&', '|', '/' with data_b=0, or an invalid opcode: outputs update on the accepting edge and done=1 for the next cycle. Latency 1. FSM stays in IDLE.
  - '*' with a valid operand pair: go to MUL, busy=1, counter=0.
  - '/' with data_b≠0: go to DIV, busy=1, counter=0.
  - MUL/DIV: one iteration per clock. After WIDTH iterations, outputs update, busy=0, done=1 for one cycle, FSM returns to IDLE. Latency is WIDTH+1 edges from the accepting edge to the done cycle.
- start while busy=1 is ignored and not queued.
- start=1 during the done cycle is accepted, giving back-to-back operation.
- result_data, result_hi and flags hold their values from done until the next accepted start completes. They never show partial iteration values.
- Arithmetic rules (N = WIDTH):
  - '+': result_data = (A+B) mod 2^N; overflow = carry-out.
  - '-': result_data = (A-B) mod 2^N; overflow = (A<B), i.e. borrow.
  - '*': {result_hi, result_data} = A*B at 2N bits; overflow = (result_hi≠0).
  - '/': result_data = A/B, result_hi = A mod B; overflow=0.
  - '/' with B=0: result_data = all ones, result_hi = A, div_zero=1, overflow=0.
  - '&', '|': bitwise; overflow=0.
  - Invalid opcode: result_data=0, result_hi=0, all flags 0, done still pulses.
- div_zero is cleared on the completion of any other operation.
- Multiplier: shift-add, one partial product per cycle.
- Divider: restoring, one quotient bit per cycle, MSB first.

Optional Feature:
- Macro: PU_SATURATE_EN.
- Defined:
  - '+' with overflow: result_data = all ones.
  - '*' with overflow: result_data = all ones; result_hi is unchanged (still the true high half).
  - '-' with borrow: result_data = 0.
  - overflow flag behaves as without the macro.
- Undefined: wrap-around results as specified above.

Test Plan (WIDTH=8):
- '+' A=200, B=100 → done 1 cycle after start; result_data=44, overflow=1. With PU_SATURATE_EN: result_data=255.
- '-' A=3, B=5 → result_data=254, overflow=1, latency 1. '&' A=0xF0, B=0x3C → result_data=0x30, overflow=0.
- '*' A=16, B=16 → busy for 8 cycles, done at edge 9; result_data=0, result_hi=1, overflow=1. Then '*' A=15, B=17 → result_data=255, result_hi=0, overflow=0.
- '/' A=200, B=7 → done at edge 9; result_data=28, result_hi=4. Changing data_a during busy does not alter the result. A second start while busy is ignored: exactly one done pulse.
- '/' A=5, B=0 → latency 1; result_data=255, result_hi=5, div_zero=1. Following '+' 1+1 → result_data=2, div_zero=0.
- Assert reset at cycle 4 of a '/' → all outputs 0, no done pulse. A start after release ('|' 0x0F, 0xA0) → result_data=0xAF.
